// File: rtl/dm_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states, port ids, DM strobe encodings.
// DM_ARB_RR_EN (optional) selects round-robin arbitration in dm_arb_pick.
package dm_arbiter_pkg;

   typedef enum logic [1:0] {
      DMA_IDLE  = 2'd0,
      DMA_ISSUE = 2'd1,
      DMA_WAIT  = 2'd2,
      DMA_DONE  = 2'd3
   } dma_state_e;

   typedef enum logic {
      DMA_P0 = 1'b0,
      DMA_P1 = 1'b1
   } dma_port_e;

   localparam logic DM_R_ON = 1'b1;
   localparam logic DM_W_ON = 1'b1;

   // Width of a counter that must reach max_val; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/dm_arb_pick.sv
// Winner select for the two DM requesters; applied only on cycles where grant is high.
// Default: port 0 priority with starvation counter. DM_ARB_RR_EN: round-robin on ties.
module dm_arb_pick
   import dm_arbiter_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic req0,
   input  logic req1,
   input  logic grant,
   output logic win_p1
);

`ifdef DM_ARB_RR_EN

   // Remembers the last winner, so the loser of a tie takes the next tie.
   logic last_p1_q, last_p1_d;

   always_comb begin
      win_p1    = req1 & (~req0 | ~last_p1_q);
      last_p1_d = last_p1_q;
      if (grant) begin
         last_p1_d = win_p1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_p1_q <= 1'b1;
      end else begin
         last_p1_q <= last_p1_d;
      end
   end

`else

   localparam int unsigned CNT_W = cnt_width(MAX_WAIT);

   logic [CNT_W-1:0] starve_q, starve_d;
   logic             starved;

   always_comb begin
      starved  = (starve_q == CNT_W'(MAX_WAIT));
      win_p1   = req1 & (~req0 | starved);
      starve_d = starve_q;
      if (grant) begin
         if (win_p1) begin
            starve_d = '0;
         end else if (req1 && !starved) begin
            starve_d = starve_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end

`endif

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data memory.
// Arbitration policy comes from dm_arb_pick; define DM_ARB_RR_EN for round-robin.
module dm_arbiter
   import dm_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W   = 10,
   parameter int unsigned RD_LAT   = 1,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        we0,
   input  logic [31:0] addr0,
   input  logic [31:0] wdata0,
   output logic        ack0,
   output logic [31:0] rdata0,
   output logic        err0,
   output logic        stall0,
   input  logic        req1,
   input  logic        we1,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata1,
   output logic        ack1,
   output logic [31:0] rdata1,
   output logic        err1,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   output logic        dm_r,
   output logic        dm_w,
   input  logic [31:0] dm_rdata
);

   localparam int unsigned WCNT_W = cnt_width(RD_LAT);

   dma_state_e        state_q, state_d;
   dma_port_e         win_q, win_d;
   logic              we_q, we_d;
   logic              err_q, err_d;
   logic [31:0]       dm_addr_q, dm_addr_d;
   logic [31:0]       dm_wdata_q, dm_wdata_d;
   logic [31:0]       rdata0_q, rdata0_d;
   logic [31:0]       rdata1_q, rdata1_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;

   logic        grant;
   logic        pick_p1;
   logic        sel_we;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic        sel_bad;
   logic        rd_act;
   logic        wr_act;

   assign grant = (state_q == DMA_IDLE) && (req0 || req1);

   dm_arb_pick #(
      .MAX_WAIT(MAX_WAIT)
   ) u_pick (
      .clk    (clk),
      .rst    (rst),
      .req0   (req0),
      .req1   (req1),
      .grant  (grant),
      .win_p1 (pick_p1)
   );

   always_comb begin
      sel_we    = pick_p1 ? we1    : we0;
      sel_addr  = pick_p1 ? addr1  : addr0;
      sel_wdata = pick_p1 ? wdata1 : wdata0;
      // Misaligned, or beyond the implemented DM word range.
      sel_bad   = (sel_addr[1:0] != 2'b00) || ((sel_addr >> (ADDR_W + 2)) != 32'd0);
   end

   always_comb begin
      state_d    = state_q;
      win_d      = win_q;
      we_d       = we_q;
      err_d      = err_q;
      dm_addr_d  = dm_addr_q;
      dm_wdata_d = dm_wdata_q;
      rdata0_d   = rdata0_q;
      rdata1_d   = rdata1_q;
      wcnt_d     = wcnt_q;
      unique case (state_q)
         DMA_IDLE: begin
            if (grant) begin
               win_d = pick_p1 ? DMA_P1 : DMA_P0;
               we_d  = sel_we;
               err_d = sel_bad;
               if (sel_bad) begin
                  if (pick_p1) rdata1_d = '0;
                  else         rdata0_d = '0;
                  state_d = DMA_DONE;
               end else begin
                  dm_addr_d  = sel_addr;
                  dm_wdata_d = sel_wdata;
                  state_d    = DMA_ISSUE;
               end
            end
         end
         DMA_ISSUE: begin
            if (we_q) begin
               state_d = DMA_DONE;
            end else begin
               wcnt_d  = '0;
               state_d = DMA_WAIT;
            end
         end
         DMA_WAIT: begin
            if (wcnt_q == WCNT_W'(RD_LAT - 1)) begin
               if (win_q == DMA_P1) rdata1_d = dm_rdata;
               else                 rdata0_d = dm_rdata;
               state_d = DMA_DONE;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end
         DMA_DONE: begin
            state_d = DMA_IDLE;
         end
         default: begin
            state_d = DMA_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= DMA_IDLE;
         win_q      <= DMA_P0;
         we_q       <= 1'b0;
         err_q      <= 1'b0;
         dm_addr_q  <= '0;
         dm_wdata_q <= '0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
         wcnt_q     <= '0;
      end else begin
         state_q    <= state_d;
         win_q      <= win_d;
         we_q       <= we_d;
         err_q      <= err_d;
         dm_addr_q  <= dm_addr_d;
         dm_wdata_q <= dm_wdata_d;
         rdata0_q   <= rdata0_d;
         rdata1_q   <= rdata1_d;
         wcnt_q     <= wcnt_d;
      end
   end

   // Strobes decode straight from the state register, so reset drops them at once.
   assign rd_act = ((state_q == DMA_ISSUE) && !we_q) || (state_q == DMA_WAIT);
   assign wr_act = (state_q == DMA_ISSUE) && we_q;
   assign dm_r   = rd_act ? DM_R_ON : ~DM_R_ON;
   assign dm_w   = wr_act ? DM_W_ON : ~DM_W_ON;

   assign ack0     = (state_q == DMA_DONE) && (win_q == DMA_P0);
   assign ack1     = (state_q == DMA_DONE) && (win_q == DMA_P1);
   assign err0     = ack0 & err_q;
   assign err1     = ack1 & err_q;
   assign stall0   = req0 & ~ack0;
   assign rdata0   = rdata0_q;
   assign rdata1   = rdata1_q;
   assign dm_addr  = dm_addr_q;
   assign dm_wdata = dm_wdata_q;

endmodule
